// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage and the decode stage that
// consumes its output.
//
// Contents:
//   RESET_PC, NOP_INSN   default reset PC and bubble encoding (addi x0,x0,0)
//   OPC_*                major opcodes already used by decode
//   FETCH/WAIT/HOLD      fetch FSM state encoding
//   if_id_t              packed view of one IF/ID register entry
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Major opcodes (instruction bits [6:0]).
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BCC   = 7'b1100011;
    localparam logic [6:0] OPC_LCC   = 7'b0000011;
    localparam logic [6:0] OPC_SCC   = 7'b0100011;
    localparam logic [6:0] OPC_MCC   = 7'b0010011;
    localparam logic [6:0] OPC_RCC   = 7'b0110011;
    // Multiply-accumulate lives in the custom-0 opcode space.
    localparam logic [6:0] OPC_MAC   = 7'b0001011;

    // Fetch FSM states.
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: holds the PC / instruction / valid triple seen
// by decode.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   flush                 squash the entry into a bubble (wins over load/stall)
//   load                  capture load_pc/load_insn as a valid entry
//   stall                 decode cannot accept; hold the current entry
//   load_pc, load_insn    entry to capture on load
//   pc, insn, valid       registered entry
module if_id_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic        stall,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_insn,
    output logic [31:0] pc,
    output logic [31:0] insn,
    output logic        valid
);

    if_id_t entry;

    // A bubble keeps the old PC so decode always sees a stable PC_out;
    // only the instruction and valid bit are squashed.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry.pc    <= 32'h0;
            entry.insn  <= NOP;
            entry.valid <= 1'b0;
        end else if (flush) begin
            entry.insn  <= NOP;
            entry.valid <= 1'b0;
        end else if (load) begin
            entry.pc    <= load_pc;
            entry.insn  <= load_insn;
            entry.valid <= 1'b1;
        end else if (!stall) begin
            entry.insn  <= NOP;
            entry.valid <= 1'b0;
        end
    end

    assign pc    = entry.pc;
    assign insn  = entry.insn;
    assign valid = entry.valid;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage. Keeps the architectural PC, issues one
// outstanding request at a time to instruction memory, applies redirects,
// honours decode stall and feeds the IF/ID register.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr request channel (address = current PC)
//   imem_resp_valid, imem_resp_data response channel (valid-only)
//   redirect_in, redirect_pc        taken branch/jal/jalr from execute
//   stall_in                        decode cannot accept
//   PC_out, instruction_out,
//   valid_out                       IF/ID register contents
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = inst_fetch_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSN = inst_fetch_pkg::NOP_INSN
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc,
    input  logic        stall_in,
    output logic [31:0] PC_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] buf_data;
    logic        drop;

    logic        req_fire;
    logic        load;
    logic [31:0] load_insn;
    logic [31:0] redirect_target;

    assign imem_req_valid  = (state == FETCH) && !redirect_in && !reset;
    assign imem_addr       = pc;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // IF/ID takes a new entry either straight from a response or from the
    // HOLD buffer, and never while a redirect is squashing the pipe.
    always_comb begin
        load      = 1'b0;
        load_insn = imem_resp_data;
        if (!redirect_in && !stall_in) begin
            if (state == WAIT && imem_resp_valid && !drop) begin
                load = 1'b1;
            end else if (state == HOLD) begin
                load      = 1'b1;
                load_insn = buf_data;
            end
        end
    end

    // A redirect while a request is still in flight cannot cancel it, so
    // drop marks the next response as stale and it is thrown away.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            buf_data <= NOP_INSN;
            drop     <= 1'b0;
        end else if (redirect_in) begin
            pc <= redirect_target;
            case (state)
                WAIT: begin
                    if (imem_resp_valid) begin
                        state <= FETCH;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                HOLD:    state <= FETCH;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= FETCH;
                        end else if (!stall_in) begin
                            pc    <= pc + 32'd4;
                            state <= FETCH;
                        end else begin
                            buf_data <= imem_resp_data;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_in) begin
                        pc    <= pc + 32'd4;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    if_id_reg #(
        .NOP (NOP_INSN)
    ) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_in),
        .load      (load),
        .stall     (stall_in),
        .load_pc   (req_pc),
        .load_insn (load_insn),
        .pc        (PC_out),
        .insn      (instruction_out),
        .valid     (valid_out)
    );

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage and IF/ID pipeline register. It produces the PC and instruction pair consumed by the decode stage.
- Holds the architectural PC and issues one outstanding request at a time to instruction memory over a valid/ready request and valid-only response interface.
- Applies redirects from branch/jal/jalr resolution, honours decode stall, and inserts NOP bubbles on flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- NOP_INSN, 32'h0000_0013, encoding driven on instruction_out for bubbles (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  32  fetch address (current PC).
- imem_resp_valid  input  1  response data valid; at most one per accepted request.
- imem_resp_data  input  32  instruction word.
- redirect_in  input  1  taken branch/jal/jalr from execute.
- redirect_pc  input  32  redirect target.
- stall_in  input  1  decode cannot accept; IF/ID register holds.
- PC_out  output  32  IF/ID registered PC of instruction_out.
- instruction_out  output  32  IF/ID registered instruction.
- valid_out  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset is synchronous, active-high; clock is clk.
- Reset values:
  - pc = RESET_PC; state = FETCH; drop = 0.
  - PC_out = 0; instruction_out = NOP_INSN; valid_out = 0.
  - imem_req_valid = 0 while reset is high.
- Combinational outputs:
  - imem_req_valid = (state==FETCH) && !redirect_in && !reset.
  - imem_addr = pc.
- States: FETCH, WAIT, HOLD. Only one request is outstanding at any time.
- FETCH:
  - Handshake fires when imem_req_valid && imem_req_ready.
  - On handshake: req_pc <= pc, go to WAIT. Otherwise stay in FETCH.
- WAIT, on imem_resp_valid:
  - If drop=1: clear drop, discard data, go to FETCH.
  - Else if !stall_in: load IF/ID (PC_out <= req_pc, instruction_out <= data, valid_out <= 1); pc <= pc+4; go to FETCH.
  - Else: capture data into a one-entry buffer, go to HOLD.
- HOLD: when !stall_in, load IF/ID from the buffer; pc <= pc+4; go to FETCH.
- IF/ID register when not loaded this cycle:
  - If stall_in: all three outputs hold.
  - Else: valid_out <= 0 and instruction_out <= NOP_INSN (bubble); PC_out holds.
- Redirect:
  - Priority order: reset, then redirect_in, then everything else. Redirect overrides stall_in.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - IF/ID is flushed: valid_out <= 0, instruction_out <= NOP_INSN, PC_out holds.
  - Action by state:
    - FETCH: no request is issued this cycle; stay in FETCH.
    - WAIT with no response this cycle: set drop=1, stay in WAIT.
    - WAIT with a response the same cycle: discard it, go to FETCH.
    - HOLD: discard the buffer, go to FETCH.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Latency and throughput:
  - Request in cycle n with ready=1 and response in n+1 gives valid_out=1 after edge n+2.
  - Peak throughput is one instruction per 2 cycles.
- Reset mid-operation: an in-flight response arriving after reset deasserts is not expected. The memory side is reset together with this block.

Decomposition:
- Shared package holds:
  - NOP_INSN and RESET_PC constants.
  - The opcode constants already used by decode (LUI, AUIPC, JAL, JALR, BCC, LCC, SCC, MCC, RCC, MAC).
  - The fetch state encoding (FETCH=2'd0, WAIT=2'd1, HOLD=2'd2).
- One sub-module is natural: if_id_reg, holding the PC/instruction/valid register with its load/hold/flush controls. The FSM and PC logic stay in inst_fetch.

Test Plan:
- Reset then release, imem_req_ready=1, each response one cycle later with data 32'h00A00093 at addr 0 and 32'h00108113 at addr 4 -> imem_addr sequence 0, 4, 8. PC_out/instruction_out = 0/00A00093, then 4/00108113. valid_out pulses 1 with bubbles (NOP, valid 0) between.
- stall_in=1 asserted before the response for addr 4 arrives, held 3 cycles -> block enters HOLD. IF/ID holds the addr-0 entry, no new request is issued. On release, PC_out=4 and instruction_out=00108113 next cycle.
- Redirect in WAIT: redirect_in=1 with redirect_pc=32'h0000_0103 while the addr-8 response is pending; that response arrives 2 cycles later -> response discarded. Next imem_addr = 32'h0000_0100. valid_out stays 0 until the fetch at 0x100 completes.
- Redirect coincident with stall_in=1 in HOLD -> buffer discarded, valid_out=0, instruction_out=00000013, next request to the target address.
- imem_req_ready held 0 for 4 cycles -> imem_req_valid=1 and imem_addr stable throughout, no state change.
- Redirect to 32'hFFFF_FFFC, then two fetches -> second imem_addr = 32'h0000_0000 (wrap).
